// File: rtl/conv16_feeder.sv
// conv16_feeder
//   Upstream feeder for the 16-row, 3-tap conv core.
//   It collects 3 filter weights and then 16 activation words from two
//   valid/ready streams into holding registers. It then keeps those operands
//   stable while pulsing the core enable for PE_LAT cycles, and finally flags
//   the single cycle in which the core's 8 sums are valid.
//
// Parameters
//   DW      word width of weights and activations (conv16 definition width, 16)
//   PE_LAT  cycles o_en stays high per tile (core pipeline depth), 1..15
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   i_start             tile start request, honoured only while idle
//   i_reuse_w           sampled with i_start: keep the weights already held
//   i_w_valid/i_w_data  weight stream (f1, f2, f3), o_w_ready its ready
//   i_a_valid/i_a_data  activation stream (r1..r16), o_a_ready its ready
//   o_r                 16 activation words, slice k feeds core i_r(k+1)
//   o_f                 3 weight words, slice k feeds core i_f(k+1)
//   o_en                core enable
//   o_sum_valid         one-cycle pulse: core sums valid this cycle
//   o_done              one-cycle pulse: tile complete
//   o_busy              high whenever the feeder is not idle
module conv16_feeder #(
  parameter int DW     = 16,
  parameter int PE_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_start,
  input  logic             i_reuse_w,
  input  logic             i_w_valid,
  input  logic [DW-1:0]    i_w_data,
  output logic             o_w_ready,
  input  logic             i_a_valid,
  input  logic [DW-1:0]    i_a_data,
  output logic             o_a_ready,
  output logic [16*DW-1:0] o_r,
  output logic [3*DW-1:0]  o_f,
  output logic             o_en,
  output logic             o_sum_valid,
  output logic             o_done,
  output logic             o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_A,
    S_FIRE,
    S_DRAIN
  } state_t;

  localparam logic [3:0] FIRE_LAST = 4'(PE_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_wcnt;
  logic [3:0]       r_acnt;
  logic [3:0]       r_fcnt;
  logic             r_w_loaded;
  logic [16*DW-1:0] r_r;
  logic [3*DW-1:0]  r_f;
  logic             w_w_hs;
  logic             w_a_hs;

  // Readies are decoded from the state register only, so a handshake is
  // simply valid qualified by the load state we are in.
  assign w_w_hs = i_w_valid && (r_state == S_LOAD_W);
  assign w_a_hs = i_a_valid && (r_state == S_LOAD_A);

  assign o_r = r_r;
  assign o_f = r_f;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode. Weight reuse is only honoured when a full
  // weight set has been loaded since reset.
  always_comb begin
    w_next      = r_state;
    o_w_ready   = 1'b0;
    o_a_ready   = 1'b0;
    o_en        = 1'b0;
    o_sum_valid = 1'b0;
    o_done      = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_next = (i_reuse_w && r_w_loaded) ? S_LOAD_A : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        o_w_ready = 1'b1;
        if (i_w_valid && (r_wcnt == 2'd2)) begin
          w_next = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        o_a_ready = 1'b1;
        if (i_a_valid && (r_acnt == 4'd15)) begin
          w_next = S_FIRE;
        end
      end
      S_FIRE: begin
        o_en = 1'b1;
        if (r_fcnt == FIRE_LAST) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_sum_valid = 1'b1;
        o_done      = 1'b1;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand registers and word counters. Each accepted word lands in the
  // slice selected by its counter; the counters return to zero after the
  // last word of their stream so the next tile starts at slice 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt     <= '0;
      r_acnt     <= '0;
      r_fcnt     <= '0;
      r_w_loaded <= 1'b0;
      r_r        <= '0;
      r_f        <= '0;
    end else begin
      if (w_w_hs) begin
        r_f[r_wcnt*DW +: DW] <= i_w_data;
        if (r_wcnt == 2'd2) begin
          r_wcnt     <= '0;
          r_w_loaded <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + 2'd1;
        end
      end
      if (w_a_hs) begin
        r_r[r_acnt*DW +: DW] <= i_a_data;
        if (r_acnt == 4'd15) begin
          r_acnt <= '0;
        end else begin
          r_acnt <= r_acnt + 4'd1;
        end
      end
      if (r_state == S_FIRE) begin
        if (r_fcnt == FIRE_LAST) begin
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv16_feeder.sv
// Testbench for conv16_feeder. Two instances (PE_LAT=1 and PE_LAT=3) share
// every input; they behave identically until the fire phase. A table of tile
// descriptions drives the directed cases, then random tiles follow. Expected
// operand contents come from a word-array model of what each tile loads.
module tb_conv16_feeder;

  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             i_start;
  logic             i_reuse_w;
  logic             i_w_valid;
  logic [DW-1:0]    i_w_data;
  logic             i_a_valid;
  logic [DW-1:0]    i_a_data;

  logic             o_w_ready1, o_a_ready1, o_en1, o_sum_valid1, o_done1, o_busy1;
  logic [16*DW-1:0] o_r1;
  logic [3*DW-1:0]  o_f1;
  logic             o_w_ready3, o_a_ready3, o_en3, o_sum_valid3, o_done3, o_busy3;
  logic [16*DW-1:0] o_r3;
  logic [3*DW-1:0]  o_f3;

  int checks = 0;
  int errors = 0;

  // Model: what the operand registers should hold, and whether weights exist.
  logic [DW-1:0] mR[16];
  logic [DW-1:0] mF[3];
  bit            mWLoaded;

  // Words offered by the current tile.
  logic [DW-1:0] tw[3];
  logic [DW-1:0] ta[16];

  typedef struct {
    bit            reuse;
    int            vmode;
    bit            pulse;
    int            abortAt;
    bit            desc;
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;
    int            s1;
    int            s2;
    int            s8;
    string         tag;
  } vec_t;

  conv16_feeder #(.DW(DW), .PE_LAT(1)) dut1 (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_reuse_w(i_reuse_w),
    .i_w_valid(i_w_valid), .i_w_data(i_w_data), .o_w_ready(o_w_ready1),
    .i_a_valid(i_a_valid), .i_a_data(i_a_data), .o_a_ready(o_a_ready1),
    .o_r(o_r1), .o_f(o_f1), .o_en(o_en1), .o_sum_valid(o_sum_valid1),
    .o_done(o_done1), .o_busy(o_busy1)
  );

  conv16_feeder #(.DW(DW), .PE_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_reuse_w(i_reuse_w),
    .i_w_valid(i_w_valid), .i_w_data(i_w_data), .o_w_ready(o_w_ready3),
    .i_a_valid(i_a_valid), .i_a_data(i_a_data), .o_a_ready(o_a_ready3),
    .o_r(o_r3), .o_f(o_f3), .o_en(o_en3), .o_sum_valid(o_sum_valid3),
    .o_done(o_done3), .o_busy(o_busy3)
  );

  always #5 clk = ~clk;

  function automatic logic [16*DW-1:0] packR(input logic [DW-1:0] a[16]);
    logic [16*DW-1:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*DW +: DW] = a[k];
    return v;
  endfunction

  function automatic logic [3*DW-1:0] packF(input logic [DW-1:0] a[3]);
    logic [3*DW-1:0] v;
    v = '0;
    for (int k = 0; k < 3; k++) v[k*DW +: DW] = a[k];
    return v;
  endfunction

  // Behavioural core: sum j is centred on row 2j-1 with stride 2; row 0 is
  // zero padding.
  function automatic int coreSum(input logic [16*DW-1:0] r, input logic [3*DW-1:0] f, input int j);
    int c;
    int s;
    c = 2 * j - 1;
    s = int'(f[DW +: DW]) * int'(r[(c-1)*DW +: DW]) + int'(f[2*DW +: DW]) * int'(r[c*DW +: DW]);
    if (c > 1) s = s + int'(f[0 +: DW]) * int'(r[(c-2)*DW +: DW]);
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_r1"}, 256'(o_r1), 256'(0));
    checkOutput({tag, "_f1"}, 256'(o_f1), 256'(0));
    checkOutput({tag, "_r3"}, 256'(o_r3), 256'(0));
    checkOutput({tag, "_f3"}, 256'(o_f3), 256'(0));
    checkOutput({tag, "_strobes1"},
                256'({o_w_ready1, o_a_ready1, o_en1, o_sum_valid1, o_done1, o_busy1}), 256'(0));
    checkOutput({tag, "_strobes3"},
                256'({o_w_ready3, o_a_ready3, o_en3, o_sum_valid3, o_done3, o_busy3}), 256'(0));
  endtask

  task automatic modelReset();
    for (int k = 0; k < 16; k++) mR[k] = '0;
    for (int k = 0; k < 3; k++) mF[k] = '0;
    mWLoaded = 1'b0;
  endtask

  // Valid/ready traffic in IDLE must not be accepted or change anything.
  task automatic strayIdle();
    int bad;
    bad = 0;
    i_w_valid = 1'b1;
    i_a_valid = 1'b1;
    repeat (10) begin
      i_w_data = DW'($urandom);
      i_a_data = DW'($urandom);
      @(negedge clk);
      if (o_w_ready1 || o_a_ready1 || o_busy1 || o_w_ready3 || o_a_ready3 || o_busy3) bad++;
    end
    i_w_valid = 1'b0;
    i_a_valid = 1'b0;
    checkOutput("stray_ready_busy", 256'(bad), 256'(0));
    checkOutput("stray_r", 256'(o_r1), 256'(packR(mR)));
    checkOutput("stray_f", 256'(o_f1), 256'(packF(mF)));
    checkOutput("stray_r3", 256'(o_r3), 256'(packR(mR)));
  endtask

  // Runs one tile from the IDLE state, starting at a falling edge.
  // vmode: 0 continuous valid, 1 activation valid toggling, 2 random gaps.
  task automatic applyStimulus(input bit reuse, input int vmode, input bit pulse, input int abortAt,
                               input int exS1, input int exS2, input int exS8, input string tag);
    int wi, ai, aph, wrdy, ardy;
    int en1First, en1Cnt, en3First, en3Last, en3Cnt;
    int done1At, done3At, done1Cnt, done3Cnt;
    int enInLoad, freezeBad, svBad, busyAfter, loadBad;
    bit expReuse, aborted;
    int wlen;
    logic [16*DW-1:0] expR;
    logic [3*DW-1:0]  expF;
    wi = 0; ai = 0; aph = 0; wrdy = 0; ardy = 0;
    en1First = -1; en1Cnt = 0; en3First = -1; en3Last = -1; en3Cnt = 0;
    done1At = -1; done3At = -1; done1Cnt = 0; done3Cnt = 0;
    enInLoad = 0; freezeBad = 0; svBad = 0; busyAfter = 0; loadBad = 0;
    aborted = 1'b0;
    expReuse = reuse && mWLoaded;
    wlen = expReuse ? 0 : 3;
    expR = packR(ta);
    expF = expReuse ? packF(mF) : packF(tw);

    i_start = 1'b1;
    i_reuse_w = reuse;
    i_w_valid = 1'b0;
    i_a_valid = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_en1) begin
        if (en1First < 0) en1First = t;
        en1Cnt++;
        if (o_r1 !== expR || o_f1 !== expF) freezeBad++;
      end
      if (o_en3) begin
        if (en3First < 0) en3First = t;
        en3Last = t;
        en3Cnt++;
        if (o_r3 !== expR || o_f3 !== expF) freezeBad++;
      end
      if ((o_en1 && (o_w_ready1 || o_a_ready1)) || (o_en3 && (o_w_ready3 || o_a_ready3))) enInLoad++;
      if (o_sum_valid1 !== o_done1 || o_sum_valid3 !== o_done3) svBad++;
      if (o_w_ready1 !== o_w_ready3 || o_a_ready1 !== o_a_ready3) loadBad++;
      if (o_done1) begin
        done1Cnt++;
        done1At = t;
        checkOutput({tag, "_r_at_done"}, 256'(o_r1), 256'(expR));
        checkOutput({tag, "_f_at_done"}, 256'(o_f1), 256'(expF));
        if (exS1 >= 0) begin
          checkOutput({tag, "_sum1"}, 256'(coreSum(o_r1, o_f1, 1)), 256'(exS1));
          checkOutput({tag, "_sum2"}, 256'(coreSum(o_r1, o_f1, 2)), 256'(exS2));
          checkOutput({tag, "_sum8"}, 256'(coreSum(o_r1, o_f1, 8)), 256'(exS8));
        end
      end
      if (o_done3) begin
        done3Cnt++;
        done3At = t;
      end
      if (o_w_ready1) wrdy++;
      if (o_a_ready1) ardy++;
      if ((done1At > 0 && t > done1At && o_busy1) || (done3At > 0 && t > done3At && o_busy3)) busyAfter++;
      if (pulse && o_en3 && (o_en1 || o_done1)) i_start = 1'b1;

      if (abortAt >= 0 && ai == abortAt) begin
        rstn = 1'b0;
        i_w_valid = 1'b0;
        i_a_valid = 1'b0;
        #1;
        checkReset({tag, "_midreset"});
        modelReset();
        @(negedge clk);
        rstn = 1'b1;
        aborted = 1'b1;
        break;
      end

      case (vmode)
        0: begin i_w_valid = 1'b1; i_a_valid = 1'b1; end
        1: begin i_w_valid = 1'b1; i_a_valid = (aph % 2 == 0); end
        default: begin
          i_w_valid = ($urandom_range(0, 3) != 0);
          i_a_valid = ($urandom_range(0, 3) != 0);
        end
      endcase
      i_w_data = (wi < 3) ? tw[wi] : DW'($urandom);
      i_a_data = (ai < 16) ? ta[ai] : DW'($urandom);
      if (o_a_ready1) aph++;
      if (i_w_valid && o_w_ready1) wi++;
      if (i_a_valid && o_a_ready1) ai++;
      if (done1Cnt > 0 && done3Cnt > 0 && t >= done3At + 4) break;
    end
    i_start = 1'b0;
    i_w_valid = 1'b0;
    i_a_valid = 1'b0;

    if (!aborted) begin
      checkOutput({tag, "_done1_count"}, 256'(done1Cnt), 256'(1));
      checkOutput({tag, "_done3_count"}, 256'(done3Cnt), 256'(1));
      checkOutput({tag, "_en1_count"}, 256'(en1Cnt), 256'(1));
      checkOutput({tag, "_en3_count"}, 256'(en3Cnt), 256'(3));
      checkOutput({tag, "_en3_span"}, 256'(en3Last - en3First + 1), 256'(3));
      checkOutput({tag, "_en_in_load"}, 256'(enInLoad), 256'(0));
      checkOutput({tag, "_operands_during_en"}, 256'(freezeBad), 256'(0));
      checkOutput({tag, "_sumvalid_eq_done"}, 256'(svBad), 256'(0));
      checkOutput({tag, "_busy_after_done"}, 256'(busyAfter), 256'(0));
      checkOutput({tag, "_ready_match"}, 256'(loadBad), 256'(0));
      if (expReuse) checkOutput({tag, "_wready_cycles"}, 256'(wrdy), 256'(0));
      if (vmode != 2) begin
        if (!expReuse) checkOutput({tag, "_wready_cycles"}, 256'(wrdy), 256'(3));
        checkOutput({tag, "_loada_cycles"}, 256'(ardy), 256'((vmode == 1) ? 31 : 16));
        checkOutput({tag, "_en1_cycle"}, 256'(en1First), 256'(1 + wlen + ((vmode == 1) ? 31 : 16)));
        checkOutput({tag, "_done1_cycle"}, 256'(done1At), 256'(en1First + 1));
        checkOutput({tag, "_en3_cycle"}, 256'(en3First), 256'(en1First));
        checkOutput({tag, "_done3_cycle"}, 256'(done3At), 256'(en3First + 3));
      end
      checkOutput({tag, "_r_hold"}, 256'(o_r3), 256'(expR));
      checkOutput({tag, "_f_hold"}, 256'(o_f3), 256'(expF));
      for (int k = 0; k < 16; k++) mR[k] = ta[k];
      for (int k = 0; k < 3; k++) mF[k] = expF[k*DW +: DW];
      mWLoaded = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs[6];
    rstn = 1'b0;
    i_start = 1'b0;
    i_reuse_w = 1'b0;
    i_w_valid = 1'b0;
    i_w_data = '0;
    i_a_valid = 1'b0;
    i_a_data = '0;
    modelReset();

    vecs[0] = '{1'b0, 0, 1'b0, -1, 1'b0, 16'd1, 16'd2, 16'd3, 8, 20, 92, "basic"};
    vecs[1] = '{1'b0, 1, 1'b0, -1, 1'b0, 16'd1, 16'd2, 16'd3, 8, 20, 92, "toggle"};
    vecs[2] = '{1'b1, 0, 1'b1, -1, 1'b1, 16'd9, 16'd9, 16'd9, 77, 82, 10, "reuse"};
    vecs[3] = '{1'b0, 0, 1'b1, -1, 1'b0, 16'd2, 16'd0, 16'd1, 2, 8, 44, "w201"};
    vecs[4] = '{1'b0, 0, 1'b0, 7, 1'b0, 16'd5, 16'd6, 16'd7, -1, -1, -1, "abort"};
    vecs[5] = '{1'b1, 0, 1'b0, -1, 1'b1, 16'd1, 16'd2, 16'd3, 77, 82, 10, "reuse_after_reset"};

    repeat (3) @(negedge clk);
    checkReset("reset");
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      tw[0] = vecs[v].w0;
      tw[1] = vecs[v].w1;
      tw[2] = vecs[v].w2;
      for (int k = 0; k < 16; k++) ta[k] = vecs[v].desc ? DW'(16 - k) : DW'(k + 1);
      applyStimulus(vecs[v].reuse, vecs[v].vmode, vecs[v].pulse, vecs[v].abortAt,
                    vecs[v].s1, vecs[v].s2, vecs[v].s8, vecs[v].tag);
      @(negedge clk);
      if (v == 3) strayIdle();
    end

    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 3; k++) tw[k] = DW'($urandom);
      for (int k = 0; k < 16; k++) ta[k] = DW'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), -1, -1, -1, -1, "random");
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    strayIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv16_feeder.md
Name: conv16_feeder

Overview:
- Upstream feeder for the 16-row, 3-tap conv core.
- Collects 3 filter weights and 16 activation words from two valid/ready streams into registers.
- Then holds the operands stable and pulses `en` for the core's pipeline depth.
- Flags when the core's 8 sums are valid for the downstream collector.

Parameters:
- DW, conv16_width (definition package): width of activation and weight words.
- PE_LAT, 1: cycles `o_en` is held high per tile (PE row pipeline depth); legal range 1..15.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- i_start  input  1  single-cycle tile start request; sampled only in IDLE.
- i_reuse_w  input  1  sampled with i_start; 1 = keep the current weights.
- i_w_valid  input  1  weight stream valid.
- i_w_data  input  DW  weight word; order is f1, f2, f3.
- o_w_ready  output  1  weight stream ready.
- i_a_valid  input  1  activation stream valid.
- i_a_data  input  DW  activation word; order is r1..r16.
- o_a_ready  output  1  activation stream ready.
- o_r  output  16*DW  slice [k*DW +: DW] drives core input i_r(k+1).
- o_f  output  3*DW  slice [k*DW +: DW] drives core input i_f(k+1).
- o_en  output  1  core enable.
- o_sum_valid  output  1  one-cycle pulse: core sums valid this cycle.
- o_done  output  1  one-cycle pulse: tile complete; same cycle as o_sum_valid.
- o_busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; all counters 0; o_r=0, o_f=0; w_loaded=0.
  - o_w_ready, o_a_ready, o_en, o_sum_valid, o_done, o_busy all 0.
  - Applies immediately, including mid-tile.
- States: IDLE, LOAD_W, LOAD_A, FIRE, DRAIN.
- IDLE:
  - All handshake and enable outputs are 0.
  - On i_start: if i_reuse_w=1 and w_loaded=1, go to LOAD_A; otherwise go to LOAD_W.
- LOAD_W:
  - o_w_ready=1, registered as a function of state only (no combinational path from valid).
  - On each handshake (valid & ready), o_f slice wcnt <= i_w_data and wcnt increments.
  - On the 3rd handshake: wcnt <= 0, w_loaded <= 1, go to LOAD_A.
- LOAD_A:
  - o_a_ready=1.
  - On each handshake, o_r slice acnt <= i_a_data and acnt increments.
  - On the 16th handshake: acnt <= 0, go to FIRE.
- Stalls: gaps in valid stall the FSM; no word is dropped or duplicated.
- FIRE:
  - o_en=1 for exactly PE_LAT consecutive cycles, counted by a 4-bit counter.
  - o_r and o_f are frozen.
  - After the PE_LAT-th cycle, go to DRAIN.
- DRAIN (1 cycle):
  - o_en=0, o_sum_valid=1, o_done=1.
  - Downstream samples core o_sum1..o_sum8 in this cycle.
  - Go to IDLE.
- Latency: with continuous valid and PE_LAT=1, from the i_start cycle:
  - FIRE (o_en high) on cycle start+20;
  - DRAIN on cycle start+21.
- Registers:
  - o_r and o_f hold their values across tiles until overwritten.
  - A partial load is never exposed to the core, because o_en=0 outside FIRE.
- i_start outside IDLE is ignored; it is not queued.
- i_reuse_w=1 with w_loaded=0 falls back to a full weight load.
- Valid asserted outside the matching LOAD state: no handshake, no register change.
- No arithmetic in this block; all data is passed through unmodified.

Test Plan:
- Reset check: assert rstn=0 mid-LOAD_A, after 7 activation words.
  - Immediately: o_r=0, o_f=0, all strobes 0, o_busy=0.
  - A new tile then loads fresh, with w_loaded=0 forcing LOAD_W.
- Basic tile, PE_LAT=1, continuous valid, weights 1,2,3, activations 1..16:
  - o_en high exactly 1 cycle, at start+20; o_r slice k = k+1; o_f = {3,2,1}.
  - o_sum_valid and o_done at start+21.
  - With the core attached: o_sum1=8, o_sum2=20, o_sum8=92.
- Backpressure: i_a_valid toggles 1,0,1,0...
  - LOAD_A lasts 31 cycles.
  - o_r holds exactly 1..16; no duplicate or lost words.
  - o_en stays 0 throughout the load.
- Weight reuse:
  - Second tile with i_reuse_w=1: o_w_ready never rises; o_f stays {3,2,1}.
  - Activations 16..1 then give o_sum1=2*16+3*15=77 (with the core attached).
  - After a reset, i_reuse_w=1 still enters LOAD_W.
- PE_LAT=3:
  - o_en high exactly 3 consecutive cycles.
  - An i_start pulse during FIRE is ignored: exactly one o_done, then IDLE.
  - o_r/o_f are unchanged while o_en=1.
- Stray traffic in IDLE: i_w_valid=1 and i_a_valid=1 for 10 cycles give no ready, no register change, o_busy=0.
